// File: rtl/alu_exec_unit.sv
// Execute-stage ALU (ADD/SUB/AND/OR/SLT) with a DEPTH-entry result FIFO; result visible 1 cycle after accept.
// Backpressure: o_ready is registered (count<DEPTH), never combinational from i_ready; optional ALU_STATUS_FLAGS_EN adds per-entry flags.
package ALUControl_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } ALUControl_t;
endpackage

module alu_exec_unit
  import ALUControl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  ALUControl_t              i_ALUControl,
  input  logic [WIDTH-1:0]         i_SrcA,
  input  logic [WIDTH-1:0]         i_SrcB,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_ALUResult,
  output logic                     o_illegal,
`ifdef ALU_STATUS_FLAGS_EN
  output logic                     o_zero,
  output logic                     o_negative,
  output logic                     o_overflow,
`endif
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             illegal;
`ifdef ALU_STATUS_FLAGS_EN
    logic             zero;
    logic             negative;
    logic             overflow;
`endif
  } entry_t;

  // Shared adder: SUB and SLT both use A + ~B + 1
  logic             do_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  entry_t           new_e;

  assign do_sub = (i_ALUControl == ALU_SUB) || (i_ALUControl == ALU_SLT);
  assign b_op   = do_sub ? ~i_SrcB : i_SrcB;
  assign sum    = i_SrcA + b_op + {{(WIDTH-1){1'b0}}, do_sub};
  assign ovf    = (i_SrcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != i_SrcA[WIDTH-1]);

  always_comb begin
    new_e = '0;
    case (i_ALUControl)
      ALU_ADD: new_e.result = sum;
      ALU_SUB: new_e.result = sum;
      ALU_AND: new_e.result = i_SrcA & i_SrcB;
      ALU_OR:  new_e.result = i_SrcA | i_SrcB;
      ALU_SLT: new_e.result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: new_e.illegal = 1'b1;
    endcase
`ifdef ALU_STATUS_FLAGS_EN
    new_e.zero     = (new_e.result == '0);
    new_e.negative = new_e.result[WIDTH-1];
    new_e.overflow = ((i_ALUControl == ALU_ADD) || (i_ALUControl == ALU_SUB)) && ovf;
`endif
  end

  entry_t          mem_q    [DEPTH];
  entry_t          mem_d    [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            rdy_q,    rdy_d;
  logic            push;
  logic            pop;

  assign push = i_valid && rdy_q;
  assign pop  = (count_q != '0) && i_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_e;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready is held low through reset and registered from the next count.
    rdy_d = (count_d < CW'(DEPTH));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  entry_t head;
  assign head        = mem_q[rd_ptr_q];
  assign o_ready     = rdy_q;
  assign o_valid     = (count_q != '0);
  assign o_count     = count_q;
  assign o_ALUResult = head.result;
  assign o_illegal   = head.illegal;
`ifdef ALU_STATUS_FLAGS_EN
  assign o_zero      = head.zero;
  assign o_negative  = head.negative;
  assign o_overflow  = head.overflow;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized + directed bench for alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;
  import ALUControl_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  ALUControl_t       i_ALUControl = ALU_ADD;
  logic [WIDTH-1:0]  i_SrcA = '0;
  logic [WIDTH-1:0]  i_SrcB = '0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [WIDTH-1:0]  o_ALUResult;
  logic              o_illegal;
`ifdef ALU_STATUS_FLAGS_EN
  logic              o_zero, o_negative, o_overflow;
`endif
  logic [$clog2(DEPTH):0] o_count;

  alu_exec_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_ALUControl(i_ALUControl), .i_SrcA(i_SrcA), .i_SrcB(i_SrcB),
    .o_valid(o_valid), .i_ready(i_ready), .o_ALUResult(o_ALUResult),
    .o_illegal(o_illegal),
`ifdef ALU_STATUS_FLAGS_EN
    .o_zero(o_zero), .o_negative(o_negative), .o_overflow(o_overflow),
`endif
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic        z;
    logic        n;
    logic        o;
  } exp_t;

  exp_t q[$];
  bit   out_of_reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on signed 64-bit values.
  function automatic exp_t ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ill = 1'b0;
    e.o   = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; e.res = a + b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; e.res = a - b; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic check_outputs();
    int sz;
    sz = q.size();
    check_eq("count", 64'(o_count), 64'(sz));
    check_eq("valid", 64'(o_valid), 64'(sz > 0));
    check_eq("ready", 64'(o_ready), 64'(out_of_reset && (sz < DEPTH)));
    if (sz > 0) begin
      check_eq("result", 64'(o_ALUResult), 64'(q[0].res));
      check_eq("illegal", 64'(o_illegal), 64'(q[0].ill));
`ifdef ALU_STATUS_FLAGS_EN
      check_eq("zero", 64'(o_zero), 64'(q[0].z));
      check_eq("negative", 64'(o_negative), 64'(q[0].n));
      check_eq("overflow", 64'(o_overflow), 64'(q[0].o));
`endif
    end
  endtask

  // One clock: present inputs, advance the model across the edge, compare.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic r);
    bit   do_push, do_pop;
    exp_t e;
    i_valid      = v;
    i_ALUControl = ALUControl_t'(op);
    i_SrcA       = a;
    i_SrcB       = b;
    i_ready      = r;
    do_push = v && out_of_reset && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    e = ref_calc(op, a, b);
    @(posedge i_clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    out_of_reset = 1'b1;
    check_outputs();
  endtask

  task automatic reset_checks();
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_ready", 64'(o_ready), 64'd0);
    check_eq("rst_count", 64'(o_count), 64'd0);
    check_eq("rst_result", 64'(o_ALUResult), 64'd0);
    check_eq("rst_illegal", 64'(o_illegal), 64'd0);
`ifdef ALU_STATUS_FLAGS_EN
    check_eq("rst_zero", 64'(o_zero), 64'd0);
    check_eq("rst_negative", 64'(o_negative), 64'd0);
    check_eq("rst_overflow", 64'(o_overflow), 64'd0);
`endif
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic mid_reset();
    i_reset = 1'b1;
    #2;
    q.delete();
    out_of_reset = 1'b0;
    reset_checks();
    @(posedge i_clk);
    #1;
    reset_checks();
    i_reset = 1'b0;
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3;
    reset_checks();
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    check_outputs();

    // ADD 5+7, consumer ready: visible next cycle, popped the cycle after
    cyc(1'b1, 3'd0, 32'd5, 32'd7, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    // SUB and SLT signed corners
    cyc(1'b1, 3'd1, 32'd3, 32'd5, 1'b1);
    cyc(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b1);
    cyc(1'b1, 3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    cyc(1'b1, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Fill with consumer stalled, third op ignored, then drain in order
    cyc(1'b1, 3'd2, 32'hF0, 32'h3C, 1'b0);
    cyc(1'b1, 3'd3, 32'hF0, 32'h0F, 1'b0);
    cyc(1'b1, 3'd0, 32'd100, 32'd100, 1'b0);
    cyc(1'b1, 3'd0, 32'd1, 32'd1, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Steady push+pop at count 1 across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'd0, 32'(i), 32'(i), 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    // Status-flag corners and illegal op
    cyc(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1);
    cyc(1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
    cyc(1'b1, 3'd1, 32'h8000_0000, 32'd1, 1'b1);
    cyc(1'b1, 3'd7, 32'h1234_5678, 32'h1, 1'b0);
    cyc(1'b1, 3'd4, 32'hFFFF, 32'h1, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    mid_reset();
    cyc(1'b1, 3'd2, 32'hFF, 32'h0F, 1'b0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        cyc(1'b1, 3'd0, 32'd1, 32'd2, 1'b0);
        cyc(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        mid_reset();
      end
      cyc(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
          pick_operand(), pick_operand(), ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
